// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier issue/collect stage.
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATAWIDTH = 32;

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    localparam int DEF_PRODW = prod_w(DEF_DATAWIDTH);

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand FIFO. Flags come from registered pointers only, so a
// write at edge N becomes visible to the read side at edge N+1.
module booth_op_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr, rd_ptr;
    logic                        push_ok, pop_ok;

    // Pointers carry one wrap bit so full/empty need no separate counter.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issue/collect stage in front of the Booth multiplier: operand FIFO, level-START
// launch control and a one-entry product slot. Tag path enabled by BOOTH_ISSUE_TAG_EN.
module booth_issue_ctrl
    import booth_pkg::*;
#(
    parameter int DATAWIDTH  = DEF_DATAWIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int TAGW       = 4
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATAWIDTH-1:0]          in_a,
    input  logic [DATAWIDTH-1:0]          in_b,
`ifdef BOOTH_ISSUE_TAG_EN
    input  logic [TAGW-1:0]               in_tag,
    output logic [TAGW-1:0]               out_tag,
`endif
    output logic                          mul_start,
    output logic [DATAWIDTH-1:0]          mul_a,
    output logic [DATAWIDTH-1:0]          mul_b,
    input  logic [prod_w(DATAWIDTH)-1:0]  mul_result,
    input  logic                          mul_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [prod_w(DATAWIDTH)-1:0]  out_result,
    output logic                          busy
);

`ifdef BOOTH_ISSUE_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif
    localparam int PW      = prod_w(DATAWIDTH);
    localparam int ENTRY_W = 2 * DATAWIDTH + (TAG_EN ? TAGW : 0);

    state_t               state;
    logic [ENTRY_W-1:0]   wr_entry, rd_entry;
    logic [DATAWIDTH-1:0] rd_a, rd_b;
    logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;

`ifdef BOOTH_ISSUE_TAG_EN
    logic [TAGW-1:0]      rd_tag, tag_q;
    assign wr_entry = {in_tag, in_a, in_b};
    assign rd_tag   = rd_entry[ENTRY_W-1 -: TAGW];
`else
    assign wr_entry = {in_a, in_b};
`endif
    assign rd_a = rd_entry[2*DATAWIDTH-1:DATAWIDTH];
    assign rd_b = rd_entry[DATAWIDTH-1:0];

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    // Launch only with an empty product slot so every Done has somewhere to land.
    assign fifo_pop  = (state == IDLE) && !fifo_empty && !out_valid;
    assign busy      = (state == RUN);

    booth_op_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .push  (fifo_push),
        .wdata (wr_entry),
        .pop   (fifo_pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
`ifdef BOOTH_ISSUE_TAG_EN
            tag_q      <= '0;
            out_tag    <= '0;
`endif
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        mul_a     <= rd_a;
                        mul_b     <= rd_b;
`ifdef BOOTH_ISSUE_TAG_EN
                        tag_q     <= rd_tag;
`endif
                        mul_start <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // START stays high through the Done cycle so the multiplier
                    // leaves its done state; it drops here, avoiding a stale relaunch.
                    if (mul_done) begin
                        out_result <= mul_result;
                        out_valid  <= 1'b1;
`ifdef BOOTH_ISSUE_TAG_EN
                        out_tag    <= tag_q;
`endif
                        mul_start  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_done_in_idle: assert property (@(posedge CLK) disable iff (!RSTn)
        !(mul_done && state == IDLE))
        else $error("mul_done seen while IDLE");
`endif

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed bench for booth_issue_ctrl with a behavioural level-START multiplier.
module tb_booth_issue_ctrl;

    localparam int DW   = 32;
    localparam int PW   = 2 * DW;
    localparam int TAGW = 4;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic          mul_start;
    logic [DW-1:0] mul_a, mul_b;
    logic [PW-1:0] mul_result;
    logic          mul_done;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_result;
    logic          busy;
`ifdef BOOTH_ISSUE_TAG_EN
    logic [TAGW-1:0] out_tag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    booth_issue_ctrl #(.DATAWIDTH(DW), .FIFO_DEPTH(4), .TAGW(TAGW)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
`ifdef BOOTH_ISSUE_TAG_EN
        .in_tag     (in_tag),
        .out_tag    (out_tag),
`endif
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    // Multiplier: Done pulses 67 edges after the edge that raised START,
    // then waits in a done state until START falls.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t mst;
    int      mcnt;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mst        <= M_IDLE;
            mcnt       <= 0;
            mul_done   <= 1'b0;
            mul_result <= '0;
        end else begin
            case (mst)
                M_IDLE: if (mul_start) begin mst <= M_RUN; mcnt <= 1; end
                M_RUN: begin
                    mcnt <= mcnt + 1;
                    if (mcnt == 66) begin
                        mul_done   <= 1'b1;
                        mul_result <= $signed(mul_a) * $signed(mul_b);
                        mst        <= M_DONE;
                    end
                end
                default: begin
                    mul_done <= 1'b0;
                    if (!mul_start) mst <= M_IDLE;
                end
            endcase
        end
    end

    // Consumer-side monitor plus START/Done relationship watch.
    logic [PW-1:0]   got[$];
    logic [TAGW-1:0] gtag[$];
    int   n_done = 0;
    int   gap_viol = 0;
    logic prev_done = 1'b0;

    always @(negedge CLK) begin
        if (RSTn) begin
            if (out_valid && out_ready) begin
                got.push_back(out_result);
`ifdef BOOTH_ISSUE_TAG_EN
                gtag.push_back(out_tag);
`else
                gtag.push_back('0);
`endif
            end
            if (prev_done && mul_start) gap_viol++;
            if (mul_done && !mul_start) gap_viol++;
            if (mul_done) n_done++;
            prev_done = mul_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [PW-1:0] got_v, input logic [PW-1:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TAGW-1:0] t);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        while (!in_ready && n < 1000) begin @(posedge CLK); #1; n++; end
        if (!in_ready) chk("push_timeout", 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got.size() < n && c < 2000) begin @(posedge CLK); #1; c++; end
        if (got.size() < n) chk("wait_got_timeout", 64'(got.size()), 64'(n));
    endtask

    task automatic wait_out_valid();
        int c = 0;
        while (!out_valid && c < 500) begin @(posedge CLK); #1; c++; end
        if (!out_valid) chk("wait_ov_timeout", 0, 1);
    endtask

    initial begin
        int cnt, viol, base;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready",   64'(in_ready),  1);
        chk("rst_mul_start",  64'(mul_start), 0);
        chk("rst_mul_a",      64'(mul_a),     0);
        chk("rst_mul_b",      64'(mul_b),     0);
        chk("rst_out_valid",  64'(out_valid), 0);
        chk("rst_out_result", out_result,     0);
        chk("rst_busy",       64'(busy),      0);
        @(negedge CLK); RSTn = 1'b1;
        @(posedge CLK); #1;

        // Single op: latency from accepting edge to out_valid.
        push(32'd3, 32'd5, 4'd0);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(posedge CLK); #1; cnt++;
            if (cnt == 1) begin
                chk("start_rise", 64'(mul_start), 1);
                chk("busy_run",   64'(busy),      1);
                chk("mul_a_3",    64'(mul_a),     3);
                chk("mul_b_5",    64'(mul_b),     5);
            end
        end
        chk("latency", 64'(cnt), 69);
        chk("prod_3x5", out_result, 64'h0000_0000_0000_000F);
        chk("start_low_after", 64'(mul_start), 0);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("ov_cleared", 64'(out_valid), 0);

        // Negative operand.
        got.delete(); gtag.delete();
        push(-32'sd3, 32'd7, 4'd0);
        wait_got(1);
        chk("prod_m3x7", got[0], 64'hFFFF_FFFF_FFFF_FFEB);

        // Five back-to-back pushes, FIFO fills, products in order.
        repeat (3) @(posedge CLK); #1;
        got.delete(); gtag.delete();
        gap_viol = 0;
        base = n_done;
        push(32'd2, 32'd3, 4'd0);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0);
        push(32'h7FFF_FFFF, 32'd2, 4'd0);
        push(32'h8000_0000, 32'h8000_0000, 4'd0);
        push(32'd100, 32'hFFFF_FFFF, 4'd0);
        chk("fifo_full_ready", 64'(in_ready), 0);
        wait_got(5);
        chk("b2b_0", got[0], 64'h0000_0000_0000_0006);
        chk("b2b_1", got[1], 64'h0000_0000_0000_0001);
        chk("b2b_2", got[2], 64'h0000_0000_FFFF_FFFE);
        chk("b2b_3", got[3], 64'h4000_0000_0000_0000);
        chk("b2b_4", got[4], 64'hFFFF_FFFF_FFFF_FF9C);
        chk("b2b_done_cnt", 64'(n_done - base), 5);
        chk("start_gap", 64'(gap_viol), 0);

        // Output back-pressure: no second launch while the slot is full.
        repeat (3) @(posedge CLK); #1;
        out_ready = 1'b0;
        got.delete(); gtag.delete();
        base = n_done;
        push(32'd6, 32'd7, 4'd0);
        push(-32'sd5, -32'sd5, 4'd0);
        wait_out_valid();
        viol = 0;
        repeat (100) begin
            @(negedge CLK);
            if (busy || mul_start) viol++;
        end
        chk("bp_no_launch", 64'(viol), 0);
        chk("bp_held", out_result, 64'd42);
        out_ready = 1'b1;
        wait_got(2);
        chk("bp_0", got[0], 64'd42);
        chk("bp_1", got[1], 64'd25);
        chk("bp_done_cnt", 64'(n_done - base), 2);

        // Reset in the middle of an operation.
        repeat (3) @(posedge CLK); #1;
        got.delete(); gtag.delete();
        push(32'd9, 32'd9, 4'd0);
        cnt = 0;
        while (!mul_start && cnt < 50) begin @(posedge CLK); #1; cnt++; end
        repeat (30) @(posedge CLK);
        @(negedge CLK); RSTn = 1'b0;
        #1;
        chk("mrst_start", 64'(mul_start), 0);
        chk("mrst_busy",  64'(busy),      0);
        chk("mrst_ov",    64'(out_valid), 0);
        chk("mrst_a",     64'(mul_a),     0);
        chk("mrst_res",   out_result,     0);
        chk("mrst_ready", 64'(in_ready),  1);
        @(negedge CLK); RSTn = 1'b1;
        @(posedge CLK); #1;
        push(32'd11, -32'sd2, 4'd0);
        wait_got(1);
        chk("post_rst_prod", got[0], 64'hFFFF_FFFF_FFFF_FFEA);
        chk("post_rst_single", 64'(got.size()), 1);

`ifdef BOOTH_ISSUE_TAG_EN
        repeat (3) @(posedge CLK); #1;
        got.delete(); gtag.delete();
        push(32'd1, 32'd1, 4'd1);
        push(32'd2, 32'd2, 4'd2);
        push(32'd3, 32'd3, 4'd3);
        wait_got(3);
        chk("tag_p0", got[0], 64'd1);
        chk("tag_t0", 64'(gtag[0]), 1);
        chk("tag_p1", got[1], 64'd4);
        chk("tag_t1", 64'(gtag[1]), 2);
        chk("tag_p2", got[2], 64'd9);
        chk("tag_t2", 64'(gtag[2]), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_issue_ctrl.md
# booth_issue_ctrl

Issue/collect stage sitting directly upstream of the Booth multiplier. It buffers operand pairs from a valid/ready producer in a small FIFO and drives the multiplier's START/A/B pins under the multiplier's level-START protocol. It captures the 2×DATAWIDTH signed product on the multiplier's Done pulse and presents it to a valid/ready consumer.

## Interface
- DATAWIDTH, 32, operand width; product is 2*DATAWIDTH
- FIFO_DEPTH, 4, operand FIFO entries (power of two, ≥2)
- TAGW, 4, tag width (used only with BOOTH_ISSUE_TAG_EN)

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO not full
- in_a  in  DATAWIDTH  multiplicand (two's complement)
- in_b  in  DATAWIDTH  multiplier (two's complement)
- in_tag  in  TAGW  request tag (BOOTH_ISSUE_TAG_EN only)
- mul_start  out  1  multiplier START, registered
- mul_a  out  DATAWIDTH  multiplier A, registered
- mul_b  out  DATAWIDTH  multiplier B, registered
- mul_result  in  2*DATAWIDTH  multiplier RESULT
- mul_done  in  1  multiplier Done (one-cycle pulse)
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts
- out_result  out  2*DATAWIDTH  signed product
- out_tag  out  TAGW  tag of product (BOOTH_ISSUE_TAG_EN only)
- busy  out  1  high in RUN

## Operation
- FIFO push on in_valid & in_ready; in_ready = !full. No push-to-pop bypass: an entry written at edge N is poppable at edge N+1.
- FSM, two states:
  - IDLE: if FIFO non-empty and out_valid==0 → pop, load mul_a/mul_b (and tag register), mul_start<=1, go RUN. Otherwise hold; mul_start=0.
  - RUN: mul_a/mul_b held constant. On mul_done==1 → out_result<=mul_result, out_valid<=1, mul_start<=0, go IDLE.
- mul_start must be high during the cycle mul_done is high, so the multiplier steps out of its done state. It drops on the following edge. This prevents an unintended relaunch with stale operands.
- Launch only when the output slot is empty, so every Done pulse always has storage. No product is ever dropped.
- out_valid clears on out_valid & out_ready. In IDLE, a pop is gated by the registered out_valid, so a new launch follows at the earliest one edge after the handshake.
- mul_done while in IDLE: ignored (protocol error; a simulation assertion flags it).
- Products are passed through unmodified; no sign or width processing.

## Timing
- Reset values: in_ready=1 (FIFO empty), mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_result=0, out_tag=0, busy=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-operation clears everything; the multiplier shares RSTn, so both restart clean.
- Multiplier latency at DATAWIDTH=32: Done rises 67 edges after the first edge with START high.
- End-to-end (idle, output free): out_valid rises 69 edges after the accepting input edge.
- Back-to-back launches: at least 1 cycle with mul_start=0 between operations.
- FIFO full: in_ready=0, and in_valid is ignored. A simultaneous pop frees a slot only on the next cycle.

## Configuration
- BOOTH_ISSUE_TAG_EN:
  - Defined: in_tag/out_tag ports exist. The FIFO stores {tag,a,b}, and out_tag returns the tag of the popped entry alongside out_result.
  - Undefined: the tag ports and storage are absent; the FIFO stores {a,b} only.

## Structure
- Shared package booth_pkg: the FSM state enum (IDLE, RUN), the default DATAWIDTH, and the product-width constant.
- One sub-module: booth_op_fifo (synchronous FIFO, parameterised width/depth, full/empty flags, no bypass).

## Test plan
- Reset, then push a=3, b=5 → mul_start rises the next cycle; out_valid after 69 edges with out_result=64'h0000_0000_0000_000F.
- Push a=-3, b=7 → out_result=64'hFFFF_FFFF_FFFF_FFEB.
- Push 5 pairs with out_ready=1 → in_ready=0 after the 4th buffered entry; all 5 products are in order; mul_start is low ≥1 cycle between ops.
- Hold out_ready=0 after the first product → no second launch (busy=0, mul_start=0) until the handshake; no Done is lost.
- Assert RSTn low at cycle 30 of an op → all outputs at reset values; a new push afterward completes correctly.
- With BOOTH_ISSUE_TAG_EN, tags 1,2,3 on three pushes → out_tag sequence 1,2,3 paired with the correct products.
